// File: rtl/vga_rx_decoder_pkg.sv
// Shared VGA receive timing defaults, state encoding and helpers.
// Default timing is 640x480 at 800x521 total.
package vga_rx_decoder_pkg;

    localparam logic [9:0] DEF_HPIXELS = 10'd800;
    localparam logic [9:0] DEF_VLINES = 10'd521;
    localparam logic [9:0] DEF_HPULSE = 10'd96;
    localparam logic [9:0] DEF_VPULSE = 10'd2;
    localparam logic [9:0] DEF_HBP = 10'd144;
    localparam logic [9:0] DEF_HFP = 10'd784;
    localparam logic [9:0] DEF_VBP = 10'd31;
    localparam logic [9:0] DEF_VFP = 10'd511;
    localparam logic [1:0] DEF_LOCK_FRAMES = 2'd2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED = 2'd2
    } rx_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/vga_rx_decoder_if.sv
// Sampled VGA video bus: active-low syncs plus 3/3/2 RGB.
// The generator side drives, the decoder side receives.
interface vga_rx_decoder_if;

    logic hsync;
    logic vsync;
    logic [2:0] red_in;
    logic [2:0] green_in;
    logic [1:0] blue_in;

    modport master (
        output hsync, vsync, red_in, green_in, blue_in
    );

    modport slave (
        input hsync, vsync, red_in, green_in, blue_in
    );

endinterface

// File: rtl/vga_rx_decoder_sync_edge.sv
// Stage-1 register for one sync line with fall/rise detect.
// Idles high out of reset so a low input right after reset reads as a fall.
module vga_rx_decoder_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic fall,
    output logic rise
);

    logic cur;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= 1'b1;
            prev <= 1'b1;
        end else begin
            cur <= d;
            prev <= cur;
        end
    end

    assign fall = prev & ~cur;
    assign rise = ~prev & cur;

endmodule

// File: rtl/vga_rx_decoder.sv
// VGA receiver: recovers (hc,vc), checks sync timing, tracks lock,
// and reports active pixels plus one probe pixel per frame.
module vga_rx_decoder #(
    parameter logic [9:0] HPIXELS = vga_rx_decoder_pkg::DEF_HPIXELS,
    parameter logic [9:0] VLINES = vga_rx_decoder_pkg::DEF_VLINES,
    parameter logic [9:0] HPULSE = vga_rx_decoder_pkg::DEF_HPULSE,
    parameter logic [9:0] VPULSE = vga_rx_decoder_pkg::DEF_VPULSE,
    parameter logic [9:0] HBP = vga_rx_decoder_pkg::DEF_HBP,
    parameter logic [9:0] HFP = vga_rx_decoder_pkg::DEF_HFP,
    parameter logic [9:0] VBP = vga_rx_decoder_pkg::DEF_VBP,
    parameter logic [9:0] VFP = vga_rx_decoder_pkg::DEF_VFP,
    parameter logic [1:0] LOCK_FRAMES = vga_rx_decoder_pkg::DEF_LOCK_FRAMES
) (
    input  logic                    clk,
    input  logic                    rst,
    vga_rx_decoder_if.slave         vid,
    input  logic [9:0]              probe_x,
    input  logic [9:0]              probe_y,
    output logic                    locked,
    output logic                    frame_start,
    output logic                    px_valid,
    output logic [9:0]              px_x,
    output logic [9:0]              px_y,
    output logic [7:0]              px_rgb,
    output logic [7:0]              probe_rgb,
    output logic                    probe_done,
    output logic [7:0]              err_count
);

    import vga_rx_decoder_pkg::*;

    // In an edge cycle the counters still hold the previous sample's position.
    localparam logic [9:0] HLAST = HPIXELS - 10'd1;
    localparam logic [9:0] VLAST = VLINES - 10'd1;
    localparam logic [9:0] HPW_LAST = HPULSE - 10'd1;
    localparam logic [9:0] VPW_LAST = VPULSE - 10'd1;
    localparam logic [9:0] AW = HFP - HBP;
    localparam logic [9:0] AH = VFP - VBP;

    logic hfall;
    logic hrise;
    logic vfall;
    logic vrise;

    vga_rx_decoder_sync_edge u_hs (
        .clk  (clk),
        .rst  (rst),
        .d    (vid.hsync),
        .fall (hfall),
        .rise (hrise)
    );

    vga_rx_decoder_sync_edge u_vs (
        .clk  (clk),
        .rst  (rst),
        .d    (vid.vsync),
        .fall (vfall),
        .rise (vrise)
    );

    logic [7:0] rgb1;
    logic [7:0] rgb2;
    logic [9:0] hcnt;
    logic [9:0] vcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb1 <= '0;
            rgb2 <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            rgb1 <= {vid.red_in, vid.green_in, vid.blue_in};
            rgb2 <= rgb1;
            if (hfall)
                hcnt <= '0;
            else if (hcnt != 10'h3FF)
                hcnt <= hcnt + 10'd1;
            if (vfall)
                vcnt <= '0;
            else if (hfall && vcnt != 10'h3FF)
                vcnt <= vcnt + 10'd1;
        end
    end

    logic t_err;

    assign t_err = (hfall & (hcnt != HLAST))
                 | (~hfall & (hcnt == HPIXELS))
                 | (hrise & (hcnt != HPW_LAST))
                 | (vrise & (vcnt != VPW_LAST))
                 | (vfall & (vcnt != VLAST));

    rx_state_t state_q;
    rx_state_t state_d;
    logic [1:0] good_q;
    logic [1:0] good_d;
    logic [7:0] err_q;
    logic [7:0] err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;
            good_q <= '0;
            err_q <= '0;
        end else begin
            state_q <= state_d;
            good_q <= good_d;
            err_q <= err_d;
        end
    end

    // Errors in SEARCH are ignored, which exempts the first edges after it.
    always_comb begin
        state_d = state_q;
        good_d = good_q;
        err_d = err_q;
        unique case (state_q)
            SEARCH: begin
                if (vfall) begin
                    state_d = ACQUIRE;
                    good_d = 2'd0;
                end
            end
            ACQUIRE: begin
                if (t_err) begin
                    state_d = SEARCH;
                end else if (vfall) begin
                    good_d = good_q + 2'd1;
                    if (good_q + 2'd1 == LOCK_FRAMES)
                        state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (t_err) begin
                    state_d = SEARCH;
                    err_d = sat_inc8(err_q);
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    assign locked = (state_q == LOCKED);
    assign err_count = err_q;

    assign px_valid = locked
                    & (hcnt >= HBP) & (hcnt < HFP)
                    & (vcnt >= VBP) & (vcnt < VFP);
    assign px_x = px_valid ? (hcnt - HBP) : '0;
    assign px_y = px_valid ? (vcnt - VBP) : '0;
    assign px_rgb = px_valid ? rgb2 : '0;

    logic [9:0] prb_x;
    logic [9:0] prb_y;
    logic probe_hit;

    assign probe_hit = px_valid
                     & (prb_x < AW) & (prb_y < AH)
                     & (px_x == prb_x) & (px_y == prb_y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prb_x <= '0;
            prb_y <= '0;
            frame_start <= 1'b0;
            probe_done <= 1'b0;
            probe_rgb <= '0;
        end else begin
            if (vfall) begin
                prb_x <= probe_x;
                prb_y <= probe_y;
            end
            frame_start <= vfall;
            probe_done <= probe_hit;
            if (probe_hit)
                probe_rgb <= px_rgb;
        end
    end

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Directed bench for vga_rx_decoder on a reduced 40x30 frame
// (active 28x22 at hc 8..35, vc 3..24).
module tb_vga_rx_decoder;

    localparam int F = 40 * 30;

    logic clk = 1'b0;
    logic rst;
    logic [9:0] probe_x;
    logic [9:0] probe_y;
    logic locked;
    logic frame_start;
    logic px_valid;
    logic [9:0] px_x;
    logic [9:0] px_y;
    logic [7:0] px_rgb;
    logic [7:0] probe_rgb;
    logic probe_done;
    logic [7:0] err_count;

    vga_rx_decoder_if vid ();

    vga_rx_decoder #(
        .HPIXELS     (10'd40),
        .VLINES      (10'd30),
        .HPULSE      (10'd4),
        .VPULSE      (10'd2),
        .HBP         (10'd8),
        .HFP         (10'd36),
        .VBP         (10'd3),
        .VFP         (10'd25),
        .LOCK_FRAMES (2'd2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .vid         (vid),
        .probe_x     (probe_x),
        .probe_y     (probe_y),
        .locked      (locked),
        .frame_start (frame_start),
        .px_valid    (px_valid),
        .px_x        (px_x),
        .px_y        (px_y),
        .px_rgb      (px_rgb),
        .probe_rgb   (probe_rgb),
        .probe_done  (probe_done),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int pd_cnt = 0;
    int gh = 0;
    int gv = 0;
    int hlen = 40;
    int hpw = 4;

    function automatic logic [7:0] col(input int h, input int v);
        if (h == 18 && v == 23)
            return 8'hE3;
        return 8'(h * 3 + v);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One pixel of the reference generator; hlen/hpw revert each line.
    task automatic tick();
        logic [7:0] c;
        @(negedge clk);
        if (probe_done)
            pd_cnt++;
        c = col(gh, gv);
        vid.hsync = (gh >= hpw);
        vid.vsync = (gv >= 2);
        {vid.red_in, vid.green_in, vid.blue_in} = c;
        gh++;
        if (gh >= hlen) begin
            gh = 0;
            hlen = 40;
            hpw = 4;
            gv = (gv == 29) ? 0 : gv + 1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic goto(input int h, input int v);
        for (int i = 0; i < 2 * F && !(gh == h && gv == v); i++)
            tick();
        if (!(gh == h && gv == v))
            $fatal(1, "FAIL goto %0d,%0d not reached", h, v);
    endtask

    task automatic next_frame();
        run(1);
        goto(0, 0);
    endtask

    initial begin
        rst = 1'b1;
        vid.hsync = 1'b1;
        vid.vsync = 1'b1;
        vid.red_in = '0;
        vid.green_in = '0;
        vid.blue_in = '0;
        probe_x = 10'd10;
        probe_y = 10'd20;
        repeat (3) @(negedge clk);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(err_count), 0);
        chk("rst_pxv", 32'(px_valid), 0);
        chk("rst_prgb", 32'(probe_rgb), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_pdone", 32'(probe_done), 0);
        rst = 1'b0;

        // lock lands one clock after the third vsync fall is detected
        run(2 * F);
        chk("pre_lock", 32'(locked), 0);
        run(2);
        chk("lock_m1", 32'(locked), 0);
        chk("fs_m1", 32'(frame_start), 0);
        run(1);
        chk("lock", 32'(locked), 1);
        chk("fs", 32'(frame_start), 1);
        run(1);
        chk("fs_pulse", 32'(frame_start), 0);

        goto(18, 23);
        run(3);
        chk("px_v", 32'(px_valid), 1);
        chk("px_x", 32'(px_x), 10);
        chk("px_y", 32'(px_y), 20);
        chk("px_rgb", 32'(px_rgb), 32'hE3);
        run(1);
        chk("pdone", 32'(probe_done), 1);
        chk("prgb", 32'(probe_rgb), 32'hE3);
        probe_x = 10'd27;
        probe_y = 10'd21;
        pd_cnt = 0;

        goto(7, 24);
        run(3);
        chk("hbp_m1", 32'(px_valid), 0);
        run(1);
        chk("hbp_v", 32'(px_valid), 1);
        chk("hbp_x", 32'(px_x), 0);
        goto(35, 24);
        run(3);
        chk("hfp_v", 32'(px_valid), 1);
        chk("hfp_x", 32'(px_x), 27);
        chk("hfp_y", 32'(px_y), 21);
        chk("hfp_rgb", 32'(px_rgb), 32'h81);
        run(1);
        chk("hfp_out", 32'(px_valid), 0);
        goto(20, 25);
        run(3);
        chk("vfp_out", 32'(px_valid), 0);

        goto(0, 0);
        chk("mid_pd", 32'(pd_cnt), 0);
        chk("mid_rgb", 32'(probe_rgb), 32'hE3);
        run(F);
        chk("last_pd", 32'(pd_cnt), 1);
        chk("last_rgb", 32'(probe_rgb), 32'h81);

        probe_x = 10'd28;
        probe_y = 10'd0;
        pd_cnt = 0;
        run(F);
        chk("oor_pd", 32'(pd_cnt), 0);
        chk("oor_rgb", 32'(probe_rgb), 32'h81);
        chk("f5_lock", 32'(locked), 1);
        chk("f5_err", 32'(err_count), 0);

        // 39-clock line
        goto(0, 10);
        hlen = 39;
        goto(0, 11);
        run(2);
        chk("e1_hold", 32'(locked), 1);
        chk("e1_err0", 32'(err_count), 0);
        run(1);
        chk("e1_drop", 32'(locked), 0);
        chk("e1_err", 32'(err_count), 1);
        next_frame();
        next_frame();
        run(3);
        chk("e1_acq", 32'(locked), 0);
        next_frame();
        run(3);
        chk("e1_relock", 32'(locked), 1);
        chk("e1_errk", 32'(err_count), 1);

        // hsync low for one clock short of the pulse
        goto(0, 10);
        hpw = 3;
        goto(3, 10);
        run(2);
        chk("e3_hold", 32'(locked), 1);
        run(1);
        chk("e3_drop", 32'(locked), 0);
        chk("e3_err", 32'(err_count), 2);
        next_frame();
        goto(0, 10);
        hpw = 3;
        goto(3, 10);
        run(3);
        chk("e3_acq_lk", 32'(locked), 0);
        chk("e3_acq_err", 32'(err_count), 2);
        next_frame();
        next_frame();
        run(3);
        chk("e3_restart", 32'(locked), 0);
        next_frame();
        run(3);
        chk("e3_relock", 32'(locked), 1);

        goto(15, 10);
        run(3);
        chk("pre_rst_v", 32'(px_valid), 1);
        chk("pre_rst_x", 32'(px_x), 7);
        rst = 1'b1;
        #1;
        chk("rst2_lock", 32'(locked), 0);
        chk("rst2_pxv", 32'(px_valid), 0);
        chk("rst2_pxx", 32'(px_x), 0);
        chk("rst2_err", 32'(err_count), 0);
        chk("rst2_prgb", 32'(probe_rgb), 0);
        run(3);
        rst = 1'b0;
        next_frame();
        next_frame();
        run(3);
        chk("rst2_acq", 32'(locked), 0);
        next_frame();
        run(3);
        chk("rst2_relock", 32'(locked), 1);
        chk("rst2_errk", 32'(err_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
